// File: rtl/svm_row_sched_if.sv
// svm_row_sched_if: merged result stream leaving the row scheduler.
//   out_data  - 32-bit result word
//   out_eng   - index of the engine that produced out_data
//   out_valid - word valid
//   out_ready - sink can accept the word this cycle
// master: the scheduler (drives data/eng/valid); slave: the classifier back-end.
interface svm_row_sched_if #(
  parameter int NENG = 4
);
  localparam int EW = (NENG > 1) ? $clog2(NENG) : 1;

  logic [31:0]   out_data;
  logic [EW-1:0] out_eng;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_eng, output out_valid, input out_ready);
  modport slave  (input out_data, input out_eng, input out_valid, output out_ready);
endinterface

// File: rtl/svm_row_sched.sv
// svm_row_sched: frame-level scheduler for a bank of SVM row engines.
//   - gates the shared pixel valid into each engine with a staggered start,
//   - issues the end-of-frame dvi_bypass pulse train that flushes the engines,
//   - buffers each engine's download stream in a FIFO and merges the streams
//     round-robin onto one ready/valid output.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   fstart               frame-start pulse (honoured only when idle)
//   dvi                  pixel data valid
//   eng_dvi[NENG]        per-engine gated data valid (combinational)
//   eng_bypass[NENG]     per-engine dvi_bypass (registered)
//   eng_dvo[NENG]        per-engine download valid
//   eng_data[32*NENG]    per-engine download word, engine k at [32k+31:32k]
//   out_bus              merged result stream (svm_row_sched_if.master)
//   busy                 frame in progress
//   frame_done           one-cycle pulse when the frame has fully drained
//   overflow             sticky: a FIFO push was dropped
module svm_row_sched #(
  parameter int NENG    = 4,
  parameter int LINEW   = 320,
  parameter int FRAMEH  = 240,
  parameter int STAGGER = 8,
  parameter int NBYPASS = 8,
  parameter int FDEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fstart,
  input  logic                 dvi,
  output logic [NENG-1:0]      eng_dvi,
  output logic [NENG-1:0]      eng_bypass,
  input  logic [NENG-1:0]      eng_dvo,
  input  logic [32*NENG-1:0]   eng_data,
  svm_row_sched_if.master      out_bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int EW   = (NENG > 1)    ? $clog2(NENG)    : 1;
  localparam int CW   = (LINEW > 1)   ? $clog2(LINEW)   : 1;
  localparam int LW   = (FRAMEH > 1)  ? $clog2(FRAMEH)  : 1;
  localparam int BW   = (NBYPASS > 1) ? $clog2(NBYPASS) : 1;
  localparam int AW   = (FDEPTH > 1)  ? $clog2(FDEPTH)  : 1;
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [LW-1:0]     line_q, line_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [NENG-1:0]   en_q, en_d;

  logic [NENG-1:0]   head_valid, pop, drop, fifo_empty;
  logic [31:0]       head_data [NENG];
  logic              out_ld, found;
  logic [EW-1:0]     sel, cand, last_grant;
  int                idx;

  // The output register may take a new word whenever it is empty or its
  // current word is leaving this cycle.
  assign out_ld  = ~out_bus.out_valid | out_bus.out_ready;
  assign busy    = (state_q != IDLE);
  assign eng_dvi = (state_q == RUN) ? (en_q & {NENG{dvi}}) : '0;

  // ---------------------------------------------------------------------------
  // Frame state machine: next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    bcnt_d  = bcnt_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        col_d  = '0;
        line_d = '0;
        bcnt_d = '0;
        en_d   = '0;
        if (fstart) begin
          state_d = RUN;
          en_d[0] = 1'b1;  // engine 0 sees the very first pixel
        end
      end
      RUN: begin
        if (dvi) begin
          if (col_q == CW'(LINEW - 1)) begin
            col_d = '0;
            if (line_q == LW'(FRAMEH - 1)) begin
              state_d = FLUSH;
              bcnt_d  = '0;
            end else begin
              line_d = line_q + 1'b1;
              // Arm engine k so it is already enabled at col 0 of its start line.
              for (int k = 1; k < NENG; k++) begin
                if (int'(line_q) + 1 == k * STAGGER) en_d[k] = 1'b1;
              end
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (bcnt_q == BW'(NBYPASS - 1)) state_d = DRAIN;
        else                            bcnt_d  = bcnt_q + 1'b1;
      end
      DRAIN: begin
        if ((&fifo_empty) && (eng_dvo == '0) && out_ld) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      line_q     <= '0;
      bcnt_q     <= '0;
      en_q       <= '0;
      eng_bypass <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      bcnt_q     <= bcnt_d;
      en_q       <= en_d;
      // Bypass is high in exactly the cycles spent in FLUSH.
      eng_bypass <= (state_d == FLUSH) ? en_q : '0;
      frame_done <= (state_q == DRAIN) && (state_d == IDLE);
      overflow   <= (((state_q == IDLE) && fstart) ? 1'b0 : overflow) | (|drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-engine FIFOs with a registered head word. Capacity counts the head
  // register, so a FIFO holds FDEPTH words in total.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NENG; k++) begin : g_fifo
    logic [31:0]   mem [FDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   mem_cnt;
    logic          hv, mem_ne, full, push_ok, head_ld;
    logic [31:0]   hd;

    assign mem_ne  = (mem_cnt != '0);
    assign full    = ((mem_cnt + CNTW'(hv)) == CNTW'(FDEPTH));
    // A pop frees a slot in the same cycle, so a push onto a full FIFO that is
    // also being popped is kept.
    assign push_ok = eng_dvo[k] & (~full | pop[k]);
    assign drop[k] = eng_dvo[k] & full & ~pop[k];
    assign head_ld = mem_ne & (~hv | pop[k]);

    assign head_valid[k] = hv;
    assign head_data[k]  = hd;
    assign fifo_empty[k] = ~hv & ~mem_ne;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        mem_cnt <= '0;
        hv      <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (head_ld) rd_ptr <= rd_ptr + 1'b1;
        mem_cnt <= mem_cnt + CNTW'(push_ok) - CNTW'(head_ld);
        if (head_ld)     hv <= 1'b1;
        else if (pop[k]) hv <= 1'b0;
      end
    end

    // NOTE: storage and the head data carry no reset; the pointers, count and
    // valid flag already make their contents unobservable after reset.
    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= eng_data[32*k +: 32];
      if (head_ld) hd <= mem[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first nonempty head after last_grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    pop   = '0;
    for (int i = 1; i <= NENG; i++) begin
      idx  = (int'(last_grant) + i) % NENG;
      cand = EW'(idx);
      if (!found && head_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (out_ld && found) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_bus.out_valid <= 1'b0;
      out_bus.out_data  <= '0;
      out_bus.out_eng   <= '0;
      last_grant        <= EW'(NENG - 1);
    end else if (out_ld) begin
      out_bus.out_valid <= found;
      if (found) begin
        out_bus.out_data <= head_data[sel];
        out_bus.out_eng  <= sel;
        last_grant       <= sel;
      end
    end
  end
endmodule

// File: tb/tb_svm_row_sched.sv
module tb_svm_row_sched;
  localparam int NENG    = 4;
  localparam int LINEW   = 16;
  localparam int FRAMEH  = 32;
  localparam int STAGGER = 8;
  localparam int NBYPASS = 8;
  localparam int FDEPTH  = 16;
  localparam int NPIX    = LINEW * FRAMEH;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                fstart = 1'b0;
  logic                dvi = 1'b0;
  logic [NENG-1:0]     eng_dvi, eng_bypass;
  logic [NENG-1:0]     eng_dvo = '0;
  logic [32*NENG-1:0]  eng_data = '0;
  logic                busy, frame_done, overflow;

  svm_row_sched_if #(.NENG(NENG)) out_bus ();

  svm_row_sched #(
    .NENG(NENG), .LINEW(LINEW), .FRAMEH(FRAMEH),
    .STAGGER(STAGGER), .NBYPASS(NBYPASS), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fstart(fstart), .dvi(dvi),
    .eng_dvi(eng_dvi), .eng_bypass(eng_bypass),
    .eng_dvo(eng_dvo), .eng_data(eng_data),
    .out_bus(out_bus),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    int          eng;
  } word_t;

  word_t got_q[$];
  int    done_cnt = 0;

  // Accepted words and frame_done pulses, observed mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (reset_n && out_bus.out_valid && out_bus.out_ready) begin
      w.data = out_bus.out_data;
      w.eng  = int'(out_bus.out_eng);
      got_q.push_back(w);
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NENG-1:0] exp_mask;
    logic [31:0]     w3 [NENG][2];
    logic [31:0]     exp_q [NENG][$];
    logic [31:0]     w5 [18];
    logic [31:0]     held_d, wd;
    int              held_e, pix, cyc, bad, total, e;
    int              first [NENG];
    int              fv_c, fd_c, got_at_fd, byp_bad, dvi_seen;

    // ---------------- reset state ----------------
    dvi = 1'b1;
    out_bus.out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_valid", out_bus.out_valid, 0);
    check("rst_out_data", out_bus.out_data, 0);
    check("rst_out_eng", out_bus.out_eng, 0);
    check("rst_bypass", eng_bypass, 0);
    check("rst_eng_dvi", eng_dvi, 0);
    dvi = 1'b0;
    reset_n = 1'b1;
    out_bus.out_ready = 1'b1;
    tick();

    // ---------------- stagger, randomized dvi gaps ----------------
    fstart = 1'b1; tick(); fstart = 1'b0;
    check("busy_after_fstart", busy, 1);
    for (int k = 0; k < NENG; k++) first[k] = -1;
    pix = 0; cyc = 0; bad = 0;
    while (pix < NPIX && cyc < 4000) begin
      dvi = ($urandom_range(0, 3) != 0);
      #1;
      exp_mask = '0;
      for (int k = 0; k < NENG; k++)
        if (dvi && pix >= k * STAGGER * LINEW) exp_mask[k] = 1'b1;
      if (eng_dvi !== exp_mask) bad++;
      for (int k = 0; k < NENG; k++)
        if (dvi && eng_dvi[k] && first[k] < 0) first[k] = pix;
      if (dvi) pix++;
      tick();
      cyc++;
    end
    check("stagger_pixels", pix, NPIX);
    check("stagger_map", bad, 0);
    for (int k = 0; k < NENG; k++) check($sformatf("first_pix_eng%0d", k), first[k], k * STAGGER * LINEW);

    // ---------------- flush, plus a simultaneous 2-word burst ----------------
    got_q.delete();
    done_cnt = 0;
    fv_c = -1; fd_c = -1; got_at_fd = -1; byp_bad = 0; dvi_seen = 0;
    for (int c = 0; c < 60 && fd_c < 0; c++) begin
      dvi = (c < 12);
      eng_dvo = '0;
      if (c == 5 || c == 6) begin
        eng_dvo = '1;
        for (int k = 0; k < NENG; k++) begin
          wd = $urandom;
          w3[k][c-5] = wd;
          eng_data[32*k +: 32] = wd;
        end
      end
      #1;
      if (c < 12 && eng_bypass !== ((c < NBYPASS) ? {NENG{1'b1}} : {NENG{1'b0}})) byp_bad++;
      if (c < NBYPASS && eng_dvi != '0) dvi_seen++;
      if (out_bus.out_valid && fv_c < 0) fv_c = c;
      if (frame_done) begin
        fd_c = c;
        got_at_fd = got_q.size();
      end
      tick();
    end
    dvi = 1'b0;
    eng_dvo = '0;
    tick(); tick(); tick();
    check("flush_bypass", byp_bad, 0);
    check("flush_no_dvi", dvi_seen, 0);
    check("push_latency", fv_c, 8);
    check("rr_count", got_q.size(), 2 * NENG);
    for (int i = 0; i < 2 * NENG; i++) begin
      if (i < got_q.size()) begin
        check($sformatf("rr_eng_%0d", i), got_q[i].eng, i % NENG);
        check($sformatf("rr_data_%0d", i), got_q[i].data, w3[i % NENG][i / NENG]);
      end
    end
    check("frame_done_after_last", got_at_fd, 2 * NENG);
    check("frame_done_once", done_cnt, 1);
    check("idle_after_frame", busy, 0);

    // ---------------- backpressure ----------------
    got_q.delete();
    out_bus.out_ready = 1'b0;
    total = 0;
    for (int c = 0; c < 4; c++) begin
      eng_dvo = NENG'($urandom_range(1, (1 << NENG) - 1));
      for (int k = 0; k < NENG; k++) begin
        wd = $urandom;
        eng_data[32*k +: 32] = wd;
        if (eng_dvo[k]) begin
          exp_q[k].push_back(wd);
          total++;
        end
      end
      tick();
    end
    eng_dvo = '0;
    for (int c = 0; c < 10 && !out_bus.out_valid; c++) tick();
    check("bp_valid", out_bus.out_valid, 1);
    held_d = out_bus.out_data;
    held_e = int'(out_bus.out_eng);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_bus.out_data !== held_d || int'(out_bus.out_eng) != held_e || out_bus.out_valid !== 1'b1) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_none_accepted", got_q.size(), 0);
    out_bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < total; c++) tick();
    for (int c = 0; c < 5; c++) tick();
    check("bp_count", got_q.size(), total);
    if (got_q.size() > 0) check("bp_first_is_held", got_q[0].data, held_d);
    bad = 0;
    foreach (got_q[i]) begin
      e = got_q[i].eng;
      if (e < 0 || e >= NENG || exp_q[e].size() == 0) bad++;
      else if (exp_q[e][0] !== got_q[i].data) bad++;
      else void'(exp_q[e].pop_front());
    end
    check("bp_order", bad, 0);
    check("bp_drained_valid", out_bus.out_valid, 0);

    // ---------------- overflow ----------------
    got_q.delete();
    out_bus.out_ready = 1'b0;
    for (int j = 0; j < 18; j++) begin
      w5[j] = $urandom;
      eng_dvo = 4'b0100;
      eng_data[64 +: 32] = w5[j];
      tick();
      if (j == 16) check("ovf_not_yet", overflow, 0);
    end
    eng_dvo = '0;
    check("ovf_set", overflow, 1);
    check("ovf_head_word", out_bus.out_data, w5[0]);
    tick(); tick(); tick();
    out_bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < 17; c++) tick();
    for (int c = 0; c < 5; c++) tick();
    check("ovf_drain_count", got_q.size(), 17);
    bad = 0;
    foreach (got_q[i]) if (i >= 17 || got_q[i].data !== w5[i] || got_q[i].eng != 2) bad++;
    check("ovf_drain_words", bad, 0);
    check("ovf_sticky", overflow, 1);
    fstart = 1'b1; tick(); fstart = 1'b0;
    check("ovf_cleared", overflow, 0);

    // ---------------- reset mid-RUN at line 10 ----------------
    dvi = 1'b1;
    for (int i = 0; i < 10 * LINEW + 3; i++) tick();
    check("pre_reset_mask", eng_dvi, 4'b0011);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_eng_dvi", eng_dvi, 0);
    check("mid_rst_bypass", eng_bypass, 0);
    check("mid_rst_out_valid", out_bus.out_valid, 0);
    check("mid_rst_out_data", out_bus.out_data, 0);
    check("mid_rst_out_eng", out_bus.out_eng, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_frame_done", frame_done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    fstart = 1'b1; tick(); fstart = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (eng_dvi !== 4'b0001) bad++;
      tick();
    end
    check("restart_only_eng0", bad, 0);
    dvi = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
